serial_to_parallel: RTL
=======================

# serial_to_parallel

Stream deserializer: collects `N` consecutive `Width`-bit beats into one `N*Width`-bit word, and carries the start-of-frame and end-of-line markers across. It is the receive-side counterpart of the 128→2×64 serializer on the Dct2 output. It sits on the 64-bit AXI-Stream input of the inverse-DCT wrapper and rebuilds 8×16-bit coefficient rows (128 bits) for `Dct2D` configured as `"idct"`. A misaligned marker pulses an error and resynchronises the block.

## Interface
- `Width`, 64, input beat width in bits.
- `N`, 2, beats per output word; must be ≥1.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `s_valid_i`  in  1  input beat valid.
- `s_ready_o`  out  1  input beat ready.
- `s_sof_i`  in  1  start-of-frame on this beat.
- `s_eol_i`  in  1  end-of-line on this beat.
- `s_data_i`  in  Width  input beat data.
- `m_valid_o`  out  1  output word valid.
- `m_ready_i`  in  1  output word ready.
- `m_sof_o`  out  1  start-of-frame of the word.
- `m_eol_o`  out  1  end-of-line of the word.
- `m_data_o`  out  N*Width  output word.
- `err_o`  out  1  one-cycle pulse on a marker misalignment.

## Operation
- A beat is accepted when `s_valid_i && s_ready_o`. A word is consumed when `m_valid_o && m_ready_i`.
- **Beat counter `cnt`** (0..N-1): this is the only state. It increments on every accepted beat and wraps to 0 after beat N-1.
- **Packing:** beat k goes to `m_data_o[k*Width +: Width]`. Beat 0 is in the LSBs.
- **Accumulation:** beats 0..N-2 go into an accumulation register. When beat N-1 is accepted, the accumulator and that beat are loaded into the output register in one step.
- **Markers:**
  - `m_sof_o` is the `s_sof_i` value latched with beat 0.
  - `m_eol_o` is the `s_eol_i` value of beat N-1.
- **Ready:** `s_ready_o = !(cnt==N-1 && m_valid_o && !m_ready_i)`.
  - Non-final beats are always accepted.
  - The final beat is accepted only if the output register is empty or drains in the same cycle.
- **Output register:**
  - It sets on final-beat capture.
  - It clears on consume when there is no simultaneous capture.
  - When capture and consume happen in the same cycle, the new word is loaded and `m_valid_o` stays 1.
- **Error handling:** rules are applied in order, per accepted beat.
  1. `s_sof_i` with `cnt!=0`: drop the partial word, pulse `err_o`, and treat this beat as beat 0.
  2. `s_eol_i` with effective index `!= N-1`: drop the partial word and this beat, pulse `err_o`, set `cnt` to 0. No output is produced.
  3. A beat carrying both markers at effective index ≠ N-1 produces one `err_o` pulse, not two.
- **N=1:** every beat is final. The block acts as a registered pipeline stage with no error cases.
- **Reset:** an asynchronous `rst_ni` low at any time abandons any partial or pending word; no word is emitted for it.

## Timing
- **Reset values:**
  - `cnt=0`
  - `m_valid_o=0`
  - `m_sof_o=0`
  - `m_eol_o=0`
  - `m_data_o=0`
  - `err_o=0`
  - `s_ready_o=1` (combinational, from the reset state)
- **Latency:** the final beat is accepted at cycle t; `m_valid_o=1` with the word at t+1.
- **Throughput:** 1 beat/cycle sustained with `m_ready_i` held high, i.e. one word every N cycles.
- **Output stability:** while `m_valid_o && !m_ready_i`, `m_data_o`, `m_sof_o` and `m_eol_o` hold constant.
- **Combinational paths:** `s_ready_o` depends combinationally on `m_ready_i`. No other input→output combinational path exists.
- **`err_o`:** registered; asserts the cycle after the offending beat is accepted.
- **Input side:** `s_valid_i` may deassert between beats. `cnt` holds while no beat is accepted.

## Structure
- **Package `stream_pkg`:**
  - `CntW = (N>1) ? $clog2(N) : 1`
  - the shared `sof`/`eol` side-band struct, also used by the serializer
- **Sub-module `stream_out_reg`:**
  - a one-entry valid/ready register holding `{sof, eol, data}`
  - load and unload in the same cycle is allowed
  - reused by the serializer's output stage
- The top level holds the counter, accumulator, error logic and ready equation.

## Test plan
- **Basic packing:** N=2, beats 0x1111…1111 (sof=1) then 0x2222…2222 (eol=1), `m_ready_i=1` → at t+1 one word, `m_data_o=0x2222…2222_1111…1111`, sof=1, eol=1, `err_o=0`.
- **Backpressure:** 3 words back-to-back with `m_ready_i=0` for 5 cycles → `s_ready_o=0` only at `cnt=1` while the output is full, no data loss, words arrive in order; throughput returns to 1 beat/cycle once `m_ready_i=1`.
- **Early eol:** N=2, eol on beat 0 (0xAA…) → `err_o` pulse, no output word, `cnt=0`; the next pair packs correctly.
- **Mid-word sof:** N=4, beats A,B then C with sof → `err_o` pulse once, A,B dropped; C,D,E,F emitted as one word with sof=1.
- **Reset mid-word:** N=2, beat 0 accepted, `rst_ni` pulsed low asynchronously → all outputs at reset values, the next two beats form a clean word.
- **N=1:** random stream with random `m_ready_i` → output equals input delayed by one cycle, `err_o` never asserts.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream side-band types and helpers for the serializer/deserializer pair.
package stream_pkg;

  // Frame markers that travel alongside every stream word.
  typedef struct packed {
    logic sof;
    logic eol;
  } side_t;

  // Beat counter width; a single-beat word still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register holding {sof, eol, data}.
// The owner only loads when the entry is empty or draining this cycle.
module stream_out_reg
  import stream_pkg::*;
#(
  parameter int DataW = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  side_t            side_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output side_t            side_o,
  output logic [DataW-1:0] data_o
);

  // Load wins over unload so a same-cycle capture keeps valid high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      side_o  <= '0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      side_o  <= side_i;
      data_o  <= data_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Stream deserializer: packs N Width-bit beats (beat 0 in the LSBs) into one
// word, carrying sof from beat 0 and eol from the last beat. Misplaced markers
// drop the partial word and pulse err_o.
module serial_to_parallel
  import stream_pkg::*;
#(
  parameter int Width = 64,
  parameter int N     = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic               s_sof_i,
  input  logic               s_eol_i,
  input  logic [Width-1:0]   s_data_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               m_sof_o,
  output logic               m_eol_o,
  output logic [N*Width-1:0] m_data_o,
  output logic               err_o
);

  localparam int              CntW = cnt_width(N);
  localparam logic [CntW-1:0] Last = CntW'(N - 1);

  logic [CntW-1:0]    cnt;
  logic [CntW-1:0]    cnt_next;
  logic [CntW-1:0]    eff;
  logic               accept;
  logic               sof_err;
  logic               eol_err;
  logic               is_final;
  logic               capture;
  logic [N*Width-1:0] word;
  side_t              word_side;
  side_t              out_side;

  // The final beat stalls only while the output holds an unconsumed word.
  assign s_ready_o = !(cnt == Last && m_valid_o && !m_ready_i);
  assign accept    = s_valid_i && s_ready_o;

  // Effective beat index, marker errors and the next counter value.
  always_comb begin
    eff      = cnt;
    sof_err  = 1'b0;
    eol_err  = 1'b0;
    is_final = 1'b0;
    cnt_next = cnt;
    // A sof in mid-word restarts the word with this beat as beat 0.
    if (s_sof_i && cnt != '0) begin
      sof_err = 1'b1;
      eff     = '0;
    end
    // An eol anywhere but the last position discards the beat too.
    eol_err  = s_eol_i && (eff != Last);
    is_final = (eff == Last) && !eol_err;
    if (accept) begin
      if (eol_err || is_final) begin
        cnt_next = '0;
      end else begin
        cnt_next = eff + CntW'(1);
      end
    end
  end

  assign capture = accept && is_final;

  // Beat counter: the only control state of the packer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // One pulse per offending beat, even if it carries both markers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else begin
      err_o <= accept && (sof_err || eol_err);
    end
  end

  if (N > 1) begin : g_acc
    logic [(N-1)*Width-1:0] acc;
    logic                   sof_acc;

    // Non-final beats land in their slot; stale slots are always overwritten
    // before the word completes, so the accumulator needs no clearing.
    always_ff @(posedge clk_i) begin
      for (int k = 0; k < N - 1; k++) begin
        if (accept && !eol_err && int'(eff) == k) begin
          acc[k*Width +: Width] <= s_data_i;
        end
      end
    end

    // sof is remembered from beat 0 of the word under construction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sof_acc <= 1'b0;
      end else if (accept && !eol_err && eff == '0) begin
        sof_acc <= s_sof_i;
      end
    end

    assign word          = {s_data_i, acc};
    assign word_side.sof = sof_acc;
    assign word_side.eol = s_eol_i;
  end else begin : g_single
    assign word          = s_data_i;
    assign word_side.sof = s_sof_i;
    assign word_side.eol = s_eol_i;
  end

  stream_out_reg #(
    .DataW(N * Width)
  ) u_out (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (capture),
    .side_i (word_side),
    .data_i (word),
    .valid_o(m_valid_o),
    .ready_i(m_ready_i),
    .side_o (out_side),
    .data_o (m_data_o)
  );

  assign m_sof_o = out_side.sof;
  assign m_eol_o = out_side.eol;

endmodule
